// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register write arbiter.
// Holds the FSM state enum and width helpers.
package reg_arb_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int NUM_REQ_DEF     = 4;
  localparam int HOLD_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    COOLDOWN
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin winner search: first set req bit at or
// after ptr, scanning upward with wrap.
module rr_priority_picker
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  logic [NUM_REQ-1:0] rot;
  logic [IW:0]        off;
  logic [IW:0]        sum;

  always_comb begin
    rot = (req >> ptr) | (req << (NUM_REQ - int'(ptr)));
    off = '0;
    // Descending scan so the smallest offset wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = (IW+1)'(k);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
    winner = sum[IW-1:0];
    valid  = |req;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester at a time
// write access to a shared register, with post-write cooldown.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic                      clr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         q,
  output logic                      wr_done,
  output logic                      busy
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = cnt_w(HOLD_CYCLES);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      sel_q, sel_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [DATA_W-1:0]  q_d;
  logic               wr_done_d;
  logic [IW-1:0]      win;
  logic               win_v;
  logic [DATA_W-1:0]  lane;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (win),
    .valid  (win_v)
  );

  assign lane = wdata[int'(sel_q)*DATA_W +: DATA_W];
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt;
    q_d       = q;
    wr_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_v) begin
          sel_d   = win;
          gnt_d   = NUM_REQ'(1) << win;
          state_d = WRITE;
        end
      end
      WRITE: begin
        gnt_d     = '0;
        q_d       = lane;
        wr_done_d = 1'b1;
        ptr_d     = (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
        if (HOLD_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = COOLDOWN;
          cnt_d   = CW'(HOLD_CYCLES);
        end
      end
      COOLDOWN: begin
        if (cnt_q <= CW'(1)) state_d = IDLE;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Clear overrides any write landing on the same edge.
    if (clr) begin
      q_d       = '0;
      wr_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      q       <= '0;
      wr_done <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      q       <= q_d;
      wr_done <= wr_done_d;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: random and directed
// stimulus against a transaction-level reference model.
module tb_reg_write_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int HOLD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req, req0;
  logic [31:0]   wdata, wdata0;
  logic          clr, clr0;
  logic [NR-1:0] gnt, gnt0;
  logic [DW-1:0] q, q0;
  logic          wr_done, wr_done0;
  logic          busy, busy0;

  reg_write_arbiter #(
    .DATA_W(DW), .NUM_REQ(NR), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .clr(clr), .gnt(gnt), .q(q), .wr_done(wr_done),
    .busy(busy)
  );

  reg_write_arbiter #(
    .DATA_W(DW), .NUM_REQ(NR), .HOLD_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .wdata(wdata0),
    .clr(clr0), .gnt(gnt0), .q(q0), .wr_done(wr_done0),
    .busy(busy0)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: edge index, next edge allowed to grant,
  // round-robin pointer, pending grant awaiting its write edge.
  int            m_n = 0;
  int            m_free = 0;
  int            m_ptr = 0;
  int            m_w = 0;
  bit            m_pend = 0;
  bit            m_busy = 0;
  logic [DW-1:0] m_q = '0;
  int            gq[$];
  logic [DW-1:0] wq[$];

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      m_n = 0; m_free = 0; m_ptr = 0; m_w = 0;
      m_pend = 0; m_busy = 0; m_q = '0;
      gq.delete();
      wq.delete();
    end else begin
      m_n++;
      if (clr) m_q = '0;
      if (m_pend) begin
        m_pend = 0;
        m_ptr  = (m_w + 1) % NR;
        m_free = m_n + HOLD + 1;
        if (!clr) begin
          m_q = wdata[m_w*DW +: DW];
          wq.push_back(m_q);
        end
      end else if (m_n >= m_free && req != 0) begin
        for (int k = NR - 1; k >= 0; k--)
          if (req[(m_ptr + k) % NR]) m_w = (m_ptr + k) % NR;
        m_pend = 1;
        gq.push_back(m_w);
      end
      m_busy = m_pend || (m_n + 1 < m_free);
    end
  end

  always @(negedge clk) begin : monitor
    int w;
    if (rst_n) begin
      chk("q", q, m_q);
      chk("busy", busy, m_busy);
      chk("gnt_onehot", $countones(gnt) <= 1, 1);
      if (gnt != 0) begin
        if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
        else begin
          w = gq.pop_front();
          chk("gnt", gnt, 1 << w);
        end
      end
      if (wr_done) begin
        if (wq.size() == 0) chk("wr_done_unexpected", wr_done, 0);
        else chk("wr_data", q, wq.pop_front());
      end
    end
  end

  initial begin
    bit hit;
    req = '0; wdata = '0; clr = 1'b0;
    req0 = '0; wdata0 = '0; clr0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", wr_done, 0);
    rst_n = 1'b1;

    // single request on lane 2
    @(negedge clk);
    req = 4'b0100; wdata = 32'h00A5_0000;
    @(negedge clk);
    req = '0;
    chk("single_gnt", gnt, 4'b0100);
    @(negedge clk);
    chk("single_q", q, 8'hA5);
    chk("single_done", wr_done, 1);
    repeat (4) @(negedge clk);

    // round robin with all requesters active
    req = 4'hF; wdata = 32'h4332_2110;
    repeat (20) @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);

    // clear colliding with the write edge
    req = 4'b0001; wdata = 32'h0000_00FF;
    @(negedge clk);
    clr = 1'b1; req = 4'b0011;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_q", q, 0);
    chk("clr_done", wr_done, 0);
    hit = 0;
    for (int t = 0; t < 8 && !hit; t++) begin
      @(negedge clk);
      if (gnt != 0) hit = 1;
    end
    chk("clr_next_gnt", gnt, 4'b0010);
    req = '0;
    repeat (5) @(negedge clk);

    // request raised during cooldown
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    req = 4'b0001;
    repeat (6) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom);
      wdata = $urandom;
      clr   = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    req = '0; clr = 1'b0;
    repeat (6) @(negedge clk);

    // asynchronous reset in the middle of a write
    req = 4'b0001; wdata = 32'h0000_005A;
    hit = 0;
    for (int t = 0; t < 20 && !hit; t++) begin
      @(negedge clk);
      if (wr_done) hit = 1;
    end
    chk("wait_write", hit, 1);
    wdata = 32'h0000_0077;
    hit = 0;
    for (int t = 0; t < 20 && !hit; t++) begin
      @(posedge clk);
      #3;
      if (gnt != 0) hit = 1;
    end
    chk("wait_grant", hit, 1);
    chk("pre_rst_q", q, 8'h5A);
    rst_n = 1'b0;
    #3;
    chk("arst_q", q, 0);
    chk("arst_gnt", gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", wr_done, 0);
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // zero-cooldown instance alternating two requesters
    req0 = 4'b0011; wdata0 = 32'h0000_2211;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("h0_gnt", gnt0,
          (k % 2 == 0) ? (1 << ((k / 2) % 2)) : 0);
      chk("h0_busy", busy0, (k % 2 == 0));
      chk("h0_done", wr_done0, (k % 2));
      if (k % 2 == 1)
        chk("h0_q", q0, ((k / 2) % 2 == 1) ? 8'h22 : 8'h11);
    end
    req0 = '0;
    repeat (4) @(negedge clk);

    chk("gq_empty", gq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W SHALL default 8; width of each write lane and of the stored register.
REQ-002 Parameter NUM_REQ SHALL default 4; number of requesters, legal range 2..8.
REQ-003 Parameter HOLD_CYCLES SHALL default 2; number of idle cooldown cycles after each write, legal range 0..15.
REQ-004 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req  input  NUM_REQ  per-requester write request, level-sensitive.
REQ-007 wdata  input  NUM_REQ*DATA_W  write lanes, flattened; lane i is bits [i*DATA_W +: DATA_W].
REQ-008 clr  input  1  synchronous clear of the stored register.
REQ-009 gnt  output  NUM_REQ  registered one-hot grant.
REQ-010 q  output  DATA_W  shared stored register value.
REQ-011 wr_done  output  1  registered one-cycle pulse, high when q has just been loaded by a write.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, WRITE and COOLDOWN.
REQ-014 IDLE: if req != 0, the FSM SHALL pick the winner as the first set req bit at or after ptr, scanning upward with wrap. It SHALL then register sel = winner, set gnt = onehot(winner) and move to WRITE. If req == 0, it SHALL stay in IDLE.
REQ-015 WRITE SHALL last exactly one cycle with gnt asserted. At its closing edge: q <= wdata lane sel; wr_done <= 1; gnt <= 0; ptr <= (sel+1) mod NUM_REQ.
REQ-016 WRITE exit: the FSM SHALL go to COOLDOWN with counter = HOLD_CYCLES, or straight to IDLE if HOLD_CYCLES = 0.
REQ-017 COOLDOWN SHALL last exactly HOLD_CYCLES cycles. req SHALL be ignored throughout COOLDOWN. The FSM SHALL then enter IDLE.
REQ-018 Latency: req sampled high at edge 1 -> gnt high in cycle 1 -> q and wr_done updated after edge 2.
REQ-019 req SHALL be sampled only in IDLE. If a requester drops req while in WRITE, the write SHALL still complete using the wdata present at the WRITE closing edge.
REQ-020 gnt SHALL never have more than one bit set. wr_done SHALL be exactly one cycle wide.
REQ-021 clr high at any edge SHALL force q <= 0.
REQ-022 If clr coincides with the WRITE closing edge, clr SHALL win: q <= 0 and wr_done stays 0. ptr SHALL still advance and the FSM SHALL still proceed per REQ-016.
REQ-023 clr SHALL NOT affect the FSM state, ptr, counter or gnt.
REQ-024 Outside WRITE, q SHALL hold its value.

Reset
REQ-025 rst_n low SHALL immediately, without waiting for a clock edge, force: state = IDLE, q = 0, gnt = 0, wr_done = 0, ptr = 0, counter = 0, busy = 0.
REQ-026 Reset asserted during WRITE or COOLDOWN SHALL abort the operation; no write SHALL occur.
REQ-027 After rst_n rises, the first grant SHALL be issued no earlier than the first rising edge at which rst_n is high and req != 0.

Structure
REQ-028 Shared package reg_arb_pkg SHALL hold the state enum (IDLE, WRITE, COOLDOWN) and the default constants for DATA_W, NUM_REQ and HOLD_CYCLES.
REQ-029 The round-robin winner search SHALL be a combinational sub-module rr_priority_picker (inputs req and ptr; outputs winner index and a valid flag).
REQ-030 The counter width SHALL be $clog2(HOLD_CYCLES+1), with a minimum of 1.

Verification
REQ-031 Async reset: with q = 8'h5A, drive rst_n low 3 ns after an edge -> q = 0, gnt = 0 and busy = 0 within 3 ns, before the next clock edge.
REQ-032 Single request: req = 4'b0100, lane2 = 8'hA5 -> gnt = 4'b0100 in cycle 1; q = 8'hA5 with wr_done = 1 in cycle 2; busy high in cycles 1-3; IDLE in cycle 4.
REQ-033 Round-robin: req = 4'b1111 held, lanes = 8'h10/8'h21/8'h32/8'h43 -> grant order 0,1,2,3,0 every 4 cycles; q follows 10,21,32,43,10.
REQ-034 Clear collision: clr = 1 at the WRITE closing edge with lane0 = 8'hFF -> q = 0, wr_done = 0; the next grant goes to requester 1 if it is requesting.
REQ-035 Cooldown masking: req = 4'b0001 raised in the first COOLDOWN cycle -> gnt = 4'b0001 appears only in the cycle after IDLE is reached.
REQ-036 HOLD_CYCLES = 0 instance with req = 4'b0011 held -> alternating grants 0,1,0,1, one write every 2 cycles, busy toggling each cycle.
